simon_engine: RTL

SIMON_ENGINE -- requirements
Module: simon_engine

---
 rtl/simon_pkg.sv | 22 ++
 rtl/simon_engine_if.sv | 28 ++
 rtl/simon_lfsr.sv | 21 ++
 rtl/simon_engine.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon memory-game engine.
package simon_pkg;

  localparam int unsigned LFSR_W = 16;

  // Fibonacci taps 16,14,13,11 expressed as a right-shift feedback mask
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHOW_ON,
    ST_SHOW_OFF,
    ST_WAIT_KEY,
    ST_WIN,
    ST_LOSE
  } state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    return {^(cur & LFSR_TAPS), cur[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/simon_engine_if.sv
// Player/lamp bus between the Simon engine and its surroundings.
interface simon_engine_if #(
  parameter int unsigned NUM_KEYS = 4,
  parameter int unsigned MAX_LEN  = 16
) ();
  localparam int unsigned KW = $clog2(NUM_KEYS);
  localparam int unsigned LW = $clog2(MAX_LEN + 1);

  logic          start;
  logic          key_valid;
  logic [KW-1:0] key_idx;
  logic          show_on;
  logic [KW-1:0] show_idx;
  logic          player_turn;
  logic [LW-1:0] level;
  logic          win;
  logic          lose;

  modport master (
    output start, key_valid, key_idx,
    input  show_on, show_idx, player_turn, level, win, lose
  );

  modport slave (
    input  start, key_valid, key_idx,
    output show_on, show_idx, player_turn, level, win, lose
  );
endinterface

// File: rtl/simon_lfsr.sv
// Free-running 16-bit Fibonacci LFSR used as the game's random source.
module simon_lfsr
  import simon_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] value
);

  logic [LFSR_W-1:0] lfsr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_next(lfsr_q);
  end

  assign value = lfsr_q;

endmodule

// File: rtl/simon_engine.sv
// Simon game engine: plays back a growing random lamp sequence and checks the
// player's key presses against it.
module simon_engine
  import simon_pkg::*;
#(
  parameter int unsigned NUM_KEYS      = 4,
  parameter int unsigned MAX_LEN       = 16,
  parameter int unsigned SHOW_TICKS    = 30,
  parameter int unsigned GAP_TICKS     = 30,
  parameter int unsigned TIMEOUT_TICKS = 120,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input logic           clk,
  input logic           reset,
  simon_engine_if.slave bus
);

  localparam int unsigned KW    = $clog2(NUM_KEYS);
  localparam int unsigned LW    = $clog2(MAX_LEN + 1);
  localparam int unsigned PW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned MAX_A = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
  localparam int unsigned MAX_T = (MAX_A > TIMEOUT_TICKS) ? MAX_A : TIMEOUT_TICKS;
  localparam int unsigned CW    = $clog2(MAX_T + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [LW-1:0] level_q, level_d;

  logic [KW-1:0] mem [MAX_LEN];
  logic          mem_we;
  logic [PW-1:0] mem_waddr;

  logic [15:0]   lfsr_value;
  logic          lfsr_unused;
  logic [KW-1:0] rnd;
  logic [KW-1:0] cur_key;
  logic          last;

  simon_lfsr #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .value (lfsr_value)
  );

  assign lfsr_unused = ^lfsr_value[15:KW];

  // Fold the raw low bits into the legal key range
  always_comb begin
    rnd = lfsr_value[KW-1:0];
    if (32'(lfsr_value[KW-1:0]) >= NUM_KEYS) rnd = lfsr_value[KW-1:0] - KW'(NUM_KEYS);
  end

  assign cur_key = mem[ptr_q];
  assign last    = (LW'(ptr_q) == level_q - LW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      level_q <= level_d;
    end
  end

  // Sequence storage has no reset; only entries below level are ever read
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= rnd;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    level_d   = level_q;
    mem_we    = 1'b0;
    mem_waddr = '0;
    unique case (state_q)
      ST_IDLE, ST_WIN, ST_LOSE: begin
        if (bus.start) begin
          state_d   = ST_SHOW_ON;
          cnt_d     = '0;
          ptr_d     = '0;
          level_d   = LW'(1);
          mem_we    = 1'b1;
          mem_waddr = '0;
        end
      end
      ST_SHOW_ON: begin
        if (cnt_q == CW'(SHOW_TICKS - 1)) begin
          state_d = ST_SHOW_OFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_SHOW_OFF: begin
        if (cnt_q == CW'(GAP_TICKS - 1)) begin
          cnt_d = '0;
          if (last) begin
            ptr_d   = '0;
            state_d = ST_WAIT_KEY;
          end else begin
            ptr_d   = ptr_q + PW'(1);
            state_d = ST_SHOW_ON;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_WAIT_KEY: begin
        // A key always wins over a coincident timeout
        if (bus.key_valid) begin
          cnt_d = '0;
          if (bus.key_idx != cur_key) begin
            state_d = ST_LOSE;
          end else if (!last) begin
            ptr_d = ptr_q + PW'(1);
          end else if (level_q == LW'(MAX_LEN)) begin
            state_d = ST_WIN;
          end else begin
            mem_we    = 1'b1;
            mem_waddr = PW'(level_q);
            level_d   = level_q + LW'(1);
            ptr_d     = '0;
            state_d   = ST_SHOW_ON;
          end
        end else if (cnt_q == CW'(TIMEOUT_TICKS - 1)) begin
          state_d = ST_LOSE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.show_on     = (state_q == ST_SHOW_ON);
  assign bus.show_idx    = (state_q == ST_SHOW_ON) ? cur_key : '0;
  assign bus.player_turn = (state_q == ST_WAIT_KEY);
  assign bus.level       = level_q;
  assign bus.win         = (state_q == ST_WIN);
  assign bus.lose        = (state_q == ST_LOSE);

endmodule
